// File: rtl/pb_conditioner.sv
// Dual-channel pushbutton conditioner: 2-flop synchroniser, counter debounce and
// stuck-button lockout per channel, producing clean levels and press pulses.
module pb_channel #(
  parameter int DEB_CYCLES   = 16,
  parameter int STUCK_CYCLES = 1024,
  parameter int CNT_W        = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic pulse,
  output logic stuck
);

  typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT, LOCKED} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       sync;
  logic             s;
  logic             clean_next, pulse_next, stuck_next;

  assign s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      clean <= 1'b0;
      pulse <= 1'b0;
      stuck <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_next;
      cnt   <= cnt_next;
      clean <= clean_next;
      pulse <= pulse_next;
      stuck <= stuck_next;
    end
  end

  // cnt counts consecutive agreeing samples; every state exit reloads it, so it never wraps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = REL_WAIT;
          cnt_next   = ONE;
        end else if (cnt == STUCK_LAST) begin
          state_next = LOCKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      LOCKED: begin
        if (s) begin
          cnt_next = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered levels line up with the state.
  always_comb begin
    clean_next = (state_next == PRESSED) || (state_next == REL_WAIT);
    pulse_next = (state == PRESS_WAIT) && (state_next == PRESSED);
    stuck_next = stuck;
    if (state_next == LOCKED) begin
      stuck_next = 1'b1;
    end else if ((state_next == PRESSED) && (state != PRESSED)) begin
      stuck_next = 1'b0;
    end
  end

endmodule

module pb_conditioner #(
  parameter int DEB_CYCLES   = 16,
  parameter int STUCK_CYCLES = 1024,
  parameter int CNT_W        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl_raw,
  input  logic       pbr_raw,
  output logic       pbl_clean,
  output logic       pbr_clean,
  output logic       pbl_pulse,
  output logic       pbr_pulse,
  output logic [1:0] stuck
);

  pb_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_left (
    .clk  (clk),
    .rst  (rst),
    .raw  (pbl_raw),
    .clean(pbl_clean),
    .pulse(pbl_pulse),
    .stuck(stuck[1])
  );

  pb_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_right (
    .clk  (clk),
    .rst  (rst),
    .raw  (pbr_raw),
    .clean(pbr_clean),
    .pulse(pbr_pulse),
    .stuck(stuck[0])
  );

endmodule

// File: tb/tb_pb_conditioner.sv
// Scoreboard bench for pb_conditioner: stimulus queues hand-computed output-change
// events (cycle, value); a monitor pops one per observed change and compares.
module tb_pb_conditioner;

  localparam int DEB   = 4;
  localparam int STUCK = 20;

  logic       clk;
  logic       rst;
  logic       pbl_raw, pbr_raw;
  logic       pbl_clean, pbr_clean, pbl_pulse, pbr_pulse;
  logic [1:0] stuck;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  cyc;
  int  vectors;
  int  miscompares;

  pb_conditioner #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STUCK),
    .CNT_W       (11)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pbl_raw  (pbl_raw),
    .pbr_raw  (pbr_raw),
    .pbl_clean(pbl_clean),
    .pbr_clean(pbr_clean),
    .pbl_pulse(pbl_pulse),
    .pbr_pulse(pbr_pulse),
    .stuck    (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed tuple: {pbl_clean, pbr_clean, pbl_pulse, pbr_pulse, stuck[1], stuck[0]}
  function automatic logic [5:0] observe();
    return {pbl_clean, pbr_clean, pbl_pulse, pbr_pulse, stuck};
  endfunction

  task automatic push(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic l, input logic r);
    pbl_raw = l;
    pbr_raw = r;
  endtask

  task automatic check_output(input string name, input logic [5:0] req);
    logic [5:0] act;
    act = observe();
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  // Monitor: every change of the output tuple must match the next queued event.
  initial begin
    logic [5:0] prev, obs;
    ev_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      obs = observe();
      if (obs !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_change cyc=%0d actual=%b required=no change", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== obs) begin
            miscompares++;
            $display("[TB] FAIL event cyc=%0d actual=%b required cyc=%0d value=%b",
                     cyc, obs, e.cyc, e.val);
          end
        end
        prev = obs;
      end
    end
  end

  initial begin
    int   t, u, v;
    logic bounce [5];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    apply_stimulus(1'b0, 1'b0);
    rst = 1'b1;
    #1 rst = 1'b0;
    wait_cycles(2);
    check_output("reset_state", 6'b000000);
    #3 rst = 1'b1;
    wait_cycles(3);

    $display("[TB] basic press, left only");
    t = cyc;
    push(t + 6,  6'b101000);
    push(t + 7,  6'b100000);
    push(t + 16, 6'b000000);
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(10);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    $display("[TB] press and release bounce");
    t = cyc;
    push(t + 11, 6'b101000);
    push(t + 12, 6'b100000);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(bounce[i], 1'b0);
      wait_cycles(1);
    end
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(10);
    u = cyc;
    push(u + 8, 6'b000000);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(1);
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(1);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(15);

    $display("[TB] short glitch on right");
    apply_stimulus(1'b0, 1'b1);
    wait_cycles(3);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(10);
    check_output("glitch_rejected", 6'b000000);

    $display("[TB] stuck left button");
    t = cyc;
    push(t + 6,  6'b101000);
    push(t + 7,  6'b100000);
    push(t + 26, 6'b000010);
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(40);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(15);
    check_output("stuck_held", 6'b000010);
    v = cyc;
    push(v + 6,  6'b101000);
    push(v + 7,  6'b100000);
    push(v + 16, 6'b000000);
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(10);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    $display("[TB] simultaneous press");
    t = cyc;
    push(t + 6,  6'b111100);
    push(t + 7,  6'b110000);
    push(t + 16, 6'b000000);
    apply_stimulus(1'b1, 1'b1);
    wait_cycles(10);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    $display("[TB] async reset mid-press");
    t = cyc;
    push(t + 6,  6'b101000);
    push(t + 7,  6'b100000);
    push(t + 10, 6'b000000);
    push(t + 18, 6'b101000);
    push(t + 19, 6'b100000);
    push(t + 26, 6'b000000);
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(9);
    #3 rst = 1'b0;
    #1 check_output("async_reset", 6'b000000);
    wait_cycles(3);
    #3 rst = 1'b1;
    wait_cycles(8);
    apply_stimulus(1'b0, 1'b0);
    wait_cycles(12);

    wait_cycles(5);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_event actual=none required cyc=%0d value=%b", e.cyc, e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
  end

endmodule
